i2c_frame_ctr: RTL and testbench

- Parametrised I2C receive-side bit/byte/frame tracker and the successor of the fixed-width I2C bit/byte counter.
- Counts SCL-qualified bit strobes and assembles each data byte MSB-first. Samples the ACK/NACK slot.
- Frame length is run-time programmable; NACK aborts and overruns are reported as sticky flags.
- Sits between the I2C bit-level front end (which supplies next_in/sda_in) and the filter register bank.

---
 rtl/i2c_frame_ctr.sv | 170 +++++++++++++++++
 tb/tb_i2c_frame_ctr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_ctr.sv
// i2c_frame_ctr
//   I2C receive-side bit/byte/frame tracker. Counts SCL-qualified bit strobes,
//   assembles each data byte MSB-first, samples the ACK/NACK slot and tracks
//   completion of a frame whose length is latched at frame start.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   clr_in              synchronous clear of counters, shift reg and sticky flags
//   byteen_in           frame enable; low holds the block idle
//   next_in, sda_in     one-cycle bit strobe and its bit value
//   frame_len_in        expected data bytes per frame (latched, clamped 1..MAX_BYTES)
//   bitidx_out          bit counter 0..DATA_BITS (DATA_BITS = ACK slot)
//   bytecnt_out         acknowledged bytes in the current frame
//   data_out            last assembled byte, byte_valid_out pulses on update
//   byteok_out          level, high during the ACK slot
//   ack_valid_out       pulse when the ACK slot is sampled
//   frameok_out         level, frame completed
//   nack_out            sticky, NACK seen
//   overrun_out         sticky, strobe after frame completion
module i2c_frame_ctr #(
  parameter  int DATA_BITS = 8,
  parameter  int MAX_BYTES = 16,
  localparam int BW        = $clog2(MAX_BYTES + 1),
  localparam int IW        = $clog2(DATA_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_in,
  input  logic                 byteen_in,
  input  logic                 next_in,
  input  logic                 sda_in,
  input  logic [BW-1:0]        frame_len_in,
  output logic [IW-1:0]        bitidx_out,
  output logic [BW-1:0]        bytecnt_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 byte_valid_out,
  output logic                 byteok_out,
  output logic                 ack_valid_out,
  output logic                 frameok_out,
  output logic                 nack_out,
  output logic                 overrun_out
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ACK, S_DONE, S_ERR} state_t;

  state_t               r_state,      w_state_nxt;
  logic [BW-1:0]        r_len,        w_len_nxt;
  logic [IW-1:0]        r_bitidx,     w_bitidx_nxt;
  logic [BW-1:0]        r_bytecnt,    w_bytecnt_nxt;
  // Only DATA_BITS-1 bits are kept: the final bit is taken straight from
  // sda_in when the byte completes.
  logic [DATA_BITS-2:0] r_shift,      w_shift_nxt;
  logic [DATA_BITS-1:0] r_data,       w_data_nxt;
  logic                 r_byte_vld,   w_byte_vld_nxt;
  logic                 r_ack_vld,    w_ack_vld_nxt;
  logic                 r_nack,       w_nack_nxt;
  logic                 r_overrun,    w_overrun_nxt;

  logic [DATA_BITS-1:0] w_shift_full;
  logic [BW-1:0]        w_len_clamp;
  logic [BW-1:0]        w_cnt_inc;

  assign w_shift_full = {r_shift, sda_in};
  assign w_cnt_inc    = r_bytecnt + BW'(1);

  always_comb begin
    w_len_clamp = frame_len_in;
    if (frame_len_in == '0)                  w_len_clamp = BW'(1);
    else if (frame_len_in > BW'(MAX_BYTES))  w_len_clamp = BW'(MAX_BYTES);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_bitidx_nxt   = r_bitidx;
    w_bytecnt_nxt  = r_bytecnt;
    w_shift_nxt    = r_shift;
    w_data_nxt     = r_data;
    w_byte_vld_nxt = 1'b0;
    w_ack_vld_nxt  = 1'b0;
    w_nack_nxt     = r_nack;
    w_overrun_nxt  = r_overrun;

    if (clr_in) begin
      w_state_nxt   = S_IDLE;
      w_bitidx_nxt  = '0;
      w_bytecnt_nxt = '0;
      w_shift_nxt   = '0;
      w_data_nxt    = '0;
      w_nack_nxt    = 1'b0;
      w_overrun_nxt = 1'b0;
    end else if (!byteen_in) begin
      // data_out and the sticky flags survive a disable; counters do not
      w_state_nxt   = S_IDLE;
      w_bitidx_nxt  = '0;
      w_bytecnt_nxt = '0;
      w_shift_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // strobe in the start cycle is deliberately dropped
          w_len_nxt   = w_len_clamp;
          w_state_nxt = S_DATA;
        end
        S_DATA: if (next_in) begin
          w_shift_nxt = w_shift_full[DATA_BITS-2:0];
          if (r_bitidx == IW'(DATA_BITS - 1)) begin
            w_bitidx_nxt   = IW'(DATA_BITS);
            w_data_nxt     = w_shift_full;
            w_byte_vld_nxt = 1'b1;
            w_state_nxt    = S_ACK;
          end else begin
            w_bitidx_nxt = r_bitidx + IW'(1);
          end
        end
        S_ACK: if (next_in) begin
          w_bitidx_nxt  = '0;
          w_ack_vld_nxt = 1'b1;
          if (sda_in) begin
            w_nack_nxt  = 1'b1;
            w_state_nxt = S_ERR;
          end else begin
            w_bytecnt_nxt = w_cnt_inc;
            w_state_nxt   = (w_cnt_inc == r_len) ? S_DONE : S_DATA;
          end
        end
        S_DONE: if (next_in) w_overrun_nxt = 1'b1;
        S_ERR:  ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_bitidx   <= '0;
      r_bytecnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_byte_vld <= 1'b0;
      r_ack_vld  <= 1'b0;
      r_nack     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_bitidx   <= w_bitidx_nxt;
      r_bytecnt  <= w_bytecnt_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_byte_vld <= w_byte_vld_nxt;
      r_ack_vld  <= w_ack_vld_nxt;
      r_nack     <= w_nack_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  assign bitidx_out     = r_bitidx;
  assign bytecnt_out    = r_bytecnt;
  assign data_out       = r_data;
  assign byte_valid_out = r_byte_vld;
  assign ack_valid_out  = r_ack_vld;
  assign nack_out       = r_nack;
  assign overrun_out    = r_overrun;
  assign byteok_out     = (r_state == S_ACK);
  assign frameok_out    = (r_state == S_DONE);

endmodule

// File: tb/tb_i2c_frame_ctr.sv
// Self-checking bench for i2c_frame_ctr (DATA_BITS=8, MAX_BYTES=4).
// Directed scenarios plus randomized frames checked against a frame-level model.
module tb_i2c_frame_ctr;
  localparam int DB = 8;
  localparam int MB = 4;
  localparam int BW = $clog2(MB + 1);
  localparam int IW = $clog2(DB + 1);

  logic          clk = 1'b0;
  logic          rst, clr_in, byteen_in, next_in, sda_in;
  logic [BW-1:0] frame_len_in;
  logic [IW-1:0] bitidx_out;
  logic [BW-1:0] bytecnt_out;
  logic [DB-1:0] data_out;
  logic          byte_valid_out, byteok_out, ack_valid_out, frameok_out, nack_out, overrun_out;

  i2c_frame_ctr #(.DATA_BITS(DB), .MAX_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .clr_in(clr_in), .byteen_in(byteen_in),
    .next_in(next_in), .sda_in(sda_in), .frame_len_in(frame_len_in),
    .bitidx_out(bitidx_out), .bytecnt_out(bytecnt_out), .data_out(data_out),
    .byte_valid_out(byte_valid_out), .byteok_out(byteok_out),
    .ack_valid_out(ack_valid_out), .frameok_out(frameok_out),
    .nack_out(nack_out), .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    next_in = 1'b1;
    sda_in  = b;
    step();
    next_in = 1'b0;
    sda_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic start_frame(input int fl);
    clr_in    = 1'b1;
    byteen_in = 1'b0;
    step();
    clr_in       = 1'b0;
    byteen_in    = 1'b1;
    frame_len_in = BW'(fl);
    step();
    frame_len_in = BW'($urandom);  // must not affect the running frame
  endtask

  task automatic send_byte(input logic [DB-1:0] v);
    for (int i = 0; i < DB; i++) begin
      gap();
      strobe(v[DB-1-i]);
      if (i < DB - 1) chk("bitidx", 32'(bitidx_out), 32'(i + 1));
    end
    chk("data", 32'(data_out), 32'(v));
    chk("bvalid", 32'(byte_valid_out), 1);
    chk("byteok", 32'(byteok_out), 1);
    chk("bitidx_ack", 32'(bitidx_out), DB);
    step();
    chk("bvalid_off", 32'(byte_valid_out), 0);
    chk("byteok_hold", 32'(byteok_out), 1);
  endtask

  task automatic send_ack(input logic a);
    strobe(a);
    chk("avalid", 32'(ack_valid_out), 1);
    chk("bitidx0", 32'(bitidx_out), 0);
    chk("byteok_off", 32'(byteok_out), 0);
  endtask

  initial begin
    int            fl, len, acked, extra;
    logic          nk, nacked;
    logic [DB-1:0] v;

    rst = 1'b1; clr_in = 1'b0; byteen_in = 1'b0; next_in = 1'b0; sda_in = 1'b0;
    frame_len_in = '0;
    #12;
    chk("rst_bitidx", 32'(bitidx_out), 0);
    chk("rst_bytecnt", 32'(bytecnt_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_flags", {26'd0, byte_valid_out, byteok_out, ack_valid_out,
                      frameok_out, nack_out, overrun_out}, 0);
    step();
    rst = 1'b0;

    // len=2: A5 then 3C
    start_frame(2);
    send_byte(8'hA5); send_ack(1'b0);
    chk("cnt1", 32'(bytecnt_out), 1);
    chk("fok_mid", 32'(frameok_out), 0);
    send_byte(8'h3C); send_ack(1'b0);
    chk("cnt2", 32'(bytecnt_out), 2);
    chk("fok_end", 32'(frameok_out), 1);

    // len=0 clamps to 1, len=7 clamps to 4
    start_frame(0);
    send_byte(8'h5A); send_ack(1'b0);
    chk("fok_len0", 32'(frameok_out), 1);
    start_frame(7);
    for (int i = 0; i < 3; i++) begin send_byte(8'(i * 37)); send_ack(1'b0); end
    chk("fok_len7_3", 32'(frameok_out), 0);
    send_byte(8'hE1); send_ack(1'b0);
    chk("fok_len7_4", 32'(frameok_out), 1);
    chk("cnt_len7", 32'(bytecnt_out), 4);

    // byteen drop mid-byte
    start_frame(2);
    send_byte(8'hA5); send_ack(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    byteen_in = 1'b0;
    step();
    chk("drop_bitidx", 32'(bitidx_out), 0);
    chk("drop_bytecnt", 32'(bytecnt_out), 0);
    chk("drop_data", 32'(data_out), 8'hA5);
    byteen_in = 1'b1;
    step();
    send_byte(8'h3C); send_ack(1'b0);
    chk("drop_cnt", 32'(bytecnt_out), 1);

    // async reset in the ACK slot, then clear of a sticky NACK
    start_frame(2);
    send_byte(8'h96);
    #2 rst = 1'b1;
    #1;
    chk("arst_byteok", 32'(byteok_out), 0);
    chk("arst_bitidx", 32'(bitidx_out), 0);
    chk("arst_data", 32'(data_out), 0);
    step();
    rst = 1'b0;
    start_frame(3);
    send_byte(8'h11); send_ack(1'b0);
    send_byte(8'h22); send_ack(1'b1);
    chk("nack_set", 32'(nack_out), 1);
    chk("nack_cnt", 32'(bytecnt_out), 1);
    chk("nack_fok", 32'(frameok_out), 0);
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    chk("nack_clr", 32'(nack_out), 0);
    chk("clr_data", 32'(data_out), 0);

    // randomized frames against a frame-level model
    for (int f = 0; f < 24; f++) begin
      fl     = $urandom_range(0, 7);
      len    = (fl == 0) ? 1 : ((fl > MB) ? MB : fl);
      acked  = 0;
      nacked = 1'b0;
      start_frame(fl);
      for (int b = 0; b < len; b++) begin
        v  = DB'($urandom);
        nk = ($urandom_range(0, 4) == 0);
        send_byte(v);
        send_ack(nk);
        if (nk) begin
          nacked = 1'b1;
          chk("r_nack", 32'(nack_out), 1);
          break;
        end
        acked++;
        chk("r_cnt", 32'(bytecnt_out), 32'(acked));
        chk("r_fok", 32'(frameok_out), 32'(acked == len));
      end
      extra = $urandom_range(0, 3);
      for (int k = 0; k < extra; k++) begin gap(); strobe(1'($urandom_range(0, 1))); end
      step();
      chk("r_overrun", 32'(overrun_out), 32'(!nacked && extra > 0));
      chk("r_fok_end", 32'(frameok_out), 32'(!nacked));
      chk("r_bitidx_end", 32'(bitidx_out), 0);
      chk("r_cnt_end", 32'(bytecnt_out), 32'(acked));
      chk("r_nack_end", 32'(nack_out), 32'(nacked));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
